fir_decimator: RTL and testbench

FIR_DECIMATOR -- requirements
Module: fir_decimator

---
 rtl/fir_decimator.sv | 90 +++++++++
 tb/tb_fir_decimator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// Keep-every-DECIM-th-sample decimator feeding a registered output FIFO with overflow drop.
// Optional FIR_DECIMATOR_DROP_CNT_EN builds a saturating dropped-sample counter on o_drop_cnt.
module fir_decimator #(
  parameter int WIDTH = 16,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_sync,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_cnt
);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0]    r_phase;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wptr, r_rptr;
  logic             r_ovf;
  logic [LW-1:0]    w_level;
  logic             w_keep, w_full, w_pop, w_push, w_drop;

  assign w_keep  = i_valid & (i_sync | (r_phase == '0));
  assign w_level = r_wptr - r_rptr;
  assign w_full  = (w_level == LW'(DEPTH));
  assign w_pop   = (w_level != '0) & i_ready;
  // A pop frees the slot in the same edge, so a full FIFO can still accept.
  assign w_push  = w_keep & (~w_full | w_pop);
  assign w_drop  = w_keep & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (i_valid) begin
      if (i_sync)
        r_phase <= (DECIM == 1) ? '0 : PW'(1);
      else if (r_phase == PW'(DECIM - 1))
        r_phase <= '0;
      else
        r_phase <= r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_ovf <= w_drop;
    end
  end

`ifdef FIR_DECIMATOR_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  // Counts at the same edge the overflow pulse is raised, saturating.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != 16'hFFFF))
      r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

  assign o_valid    = (w_level != '0);
  assign o_data     = r_mem[r_rptr[AW-1:0]];
  assign o_level    = w_level;
  assign o_overflow = r_ovf;
endmodule

// File: tb/tb_fir_decimator.sv
// Randomized and directed checks of fir_decimator against a queue-based reference model.
module tb_fir_decimator;
  localparam int TD = 4;
  localparam int TDEPTH = 4;
`ifdef FIR_DECIMATOR_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid = 0, i_sync = 0, i_ready = 0;
  logic [15:0] i_data = '0;
  logic o_valid, o_overflow;
  logic [15:0] o_data, o_drop_cnt;
  logic [2:0] o_level;

  logic d1_valid = 0, d1_sync = 0, d1_ready = 0;
  logic [15:0] d1_data = '0;
  logic d1_o_valid, d1_o_overflow;
  logic [15:0] d1_o_data, d1_o_drop_cnt;
  logic [2:0] d1_o_level;

  int tests = 0, fails = 0;

  fir_decimator #(.WIDTH(16), .DECIM(TD), .DEPTH(TDEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_sync(i_sync),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready), .o_level(o_level),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt));

  fir_decimator #(.WIDTH(16), .DECIM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .i_valid(d1_valid), .i_data(d1_data), .i_sync(d1_sync),
    .o_valid(d1_o_valid), .o_data(d1_o_data), .i_ready(d1_ready), .o_level(d1_o_level),
    .o_overflow(d1_o_overflow), .o_drop_cnt(d1_o_drop_cnt));

  always #5 clk = ~clk;

  // reference model: samples since last realign, FIFO contents, overflow flag, drops
  int m_n;
  logic [15:0] m_q[$];
  logic [15:0] got[$];
  bit m_ovf;
  int m_drop;

  function automatic logic [36:0] exp_vec();
    logic [15:0] hd;
    hd = (m_q.size() > 0) ? m_q[0] : 16'h0;
    return {m_q.size() > 0, hd, 3'(m_q.size()), m_ovf, 16'(m_drop)};
  endfunction

  function automatic logic [36:0] act_vec();
    return {o_valid, o_valid ? o_data : 16'h0, o_level, o_overflow, o_drop_cnt};
  endfunction

  task automatic model_reset();
    m_n = 0; m_q.delete(); got.delete(); m_ovf = 0; m_drop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input bit v, input bit s, input bit r, input logic [15:0] d);
    bit keep, pop, full;
    i_valid = v; i_sync = s; i_ready = r; i_data = d;
    if (o_valid && r) got.push_back(o_data);
    @(posedge clk);
    keep = v && (s || m_n == 0);
    if (v) m_n = ((s ? 0 : m_n) + 1) % TD;
    pop  = r && (m_q.size() > 0);
    full = (m_q.size() == TDEPTH);
    if (pop) void'(m_q.pop_front());
    if (keep && (!full || pop)) m_q.push_back(d);
    m_ovf = keep && full && !pop;
    if (m_ovf && DROP_EN && m_drop < 65535) m_drop++;
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({o_valid, o_data, o_level, o_overflow, o_drop_cnt} !== 37'h0) begin
      fails++; $display("FAIL reset: got %h want 0", {o_valid, o_data, o_level, o_overflow, o_drop_cnt});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_decimate();
    logic [15:0] want[4];
    want = '{16'd0, 16'd4, 16'd8, 16'd12};
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 0, 1, 16'(i));
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL decimate cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (got.size() != 4) begin
      fails++; $display("FAIL decimate_count: got %0d want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got[i] !== want[i]) begin
          fails++; $display("FAIL decimate_out%0d: got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_sync();
    logic [15:0] want[3];
    want = '{16'd100, 16'd102, 16'd106};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(i < 10, i == 2, 1, 16'(100 + i));
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL sync cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (got.size() != 3) begin
      fails++; $display("FAIL sync_count: got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== want[i]) begin
          fails++; $display("FAIL sync_out%0d: got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 16'(i));
      if (o_overflow) pulses++;
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL overflow cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (pulses != 1 || o_level !== 3'd4 || o_drop_cnt !== (DROP_EN ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL overflow_sum: pulses %0d level %0d drops %0d want 1 4 %0d",
                        pulses, o_level, o_drop_cnt, DROP_EN);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] want[5];
    want = '{16'd0, 16'd4, 16'd8, 16'd12, 16'd20};
    step(1, 0, 1, 16'd20);
    tests++;
    if (o_level !== 3'd4 || o_overflow !== 1'b0 || o_data !== 16'd4) begin
      fails++; $display("FAIL full_pop: level %0d ovf %0b head %0d want 4 0 4", o_level, o_overflow, o_data);
    end
    for (int i = 0; i < 9; i++) begin
      step(i < 3, 0, i >= 3, 16'(21 + i));
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL full_pop cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (got.size() != 5) begin
      fails++; $display("FAIL full_pop_count: got %0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (got[i] !== want[i]) begin
          fails++; $display("FAIL full_pop_out%0d: got %0d want %0d", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 16'(200 + i));
    tests++;
    if (o_level !== 3'd3) begin
      fails++; $display("FAIL reset_mid_pre: level %0d want 3", o_level);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({o_valid, o_data, o_level, o_overflow, o_drop_cnt} !== 37'h0) begin
      fails++; $display("FAIL reset_mid_async: got %h want 0", {o_valid, o_data, o_level, o_overflow, o_drop_cnt});
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 16'(77 + i));
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL reset_mid cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (o_data !== 16'd77 || o_level !== 3'd1) begin
      fails++; $display("FAIL reset_mid_first: head %0d level %0d want 77 1", o_data, o_level);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0,
           $urandom_range(1, 0) == 1, 16'($urandom));
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL random cyc%0d: got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] vals[6];
    vals = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8001, 16'h7FFE};
    do_reset();
    d1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d1_valid = 1'b1; d1_data = vals[i];
      step(0, 0, 0, 16'h0);
      tests++;
      if (d1_o_valid !== 1'b1 || d1_o_data !== vals[i] || d1_o_level !== 3'd1) begin
        fails++; $display("FAIL extremes%0d: v %0b data %h level %0d want 1 %h 1",
                          i, d1_o_valid, d1_o_data, d1_o_level, vals[i]);
      end
    end
    d1_valid = 1'b0;
    step(0, 0, 0, 16'h0);
    tests++;
    if (d1_o_valid !== 1'b0 || d1_o_level !== 3'd0) begin
      fails++; $display("FAIL extremes_drain: v %0b level %0d want 0 0", d1_o_valid, d1_o_level);
    end
    d1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decimate();
    test_sync();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    test_extremes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
